// File: rtl/la_pkg.sv
// Shared types and defaults for the capture sequencer.
// State codes are exported on state_o, so their values are fixed.
package la_pkg;

    localparam int CNT_W_D     = 17;
    localparam int SAMP_W_D    = 24;
    localparam int FLUSH_CYC_D = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FLUSH     = 3'd1,
        S_PRE_FILL  = 3'd2,
        S_WAIT_TRIG = 3'd3,
        S_POST      = 3'd4,
        S_DRAIN     = 3'd5
    } cap_state_t;

endpackage

// File: rtl/capture_cnt.sv
// Loadable down-counter that holds at zero instead of wrapping.
// Used for the flush hold time and the post-trigger word budget.
module capture_cnt #(
    parameter int W = 8
) (
    input  logic         CLK300MHZ,
    input  logic         RST,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK300MHZ or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/capture_seq.sv
// Capture sequencer: flush, pre-trigger fill, armed discard,
// post-trigger count and drain for the 300 MHz sample path.
module capture_seq
    import la_pkg::*;
#(
    parameter int CNT_W     = CNT_W_D,
    parameter int SAMP_W    = SAMP_W_D,
    parameter int FLUSH_CYC = FLUSH_CYC_D
) (
    input  logic              CLK300MHZ,
    input  logic              RST,
    input  logic              start_stb,
    input  logic              abort_stb,
    input  logic [CNT_W-1:0]  pre_depth,
    input  logic [SAMP_W-1:0] post_words,
    input  logic              trigger_in,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic              samp_stb,
    output logic              fifo_flush,
    output logic              wr_gate,
    output logic              discard_rd,
    output logic              drain_en,
    output logic              busy,
    output logic              done_stb,
    output logic [2:0]        state_o
);

    localparam int FL_W = $clog2(FLUSH_CYC) + 1;

    cap_state_t        r_state;
    cap_state_t        w_next;
    logic [CNT_W-1:0]  r_pre_q;
    logic [SAMP_W-1:0] r_post_q;
    logic              r_aborting;
    logic              r_fifo_flush;
    logic              r_wr_gate;
    logic              r_discard;
    logic              r_drain;
    logic              r_busy;
    logic              r_done;

    logic              w_fl_load;
    logic              w_fl_dec;
    logic [FL_W-1:0]   w_fl_cnt;
    logic              w_pc_load;
    logic              w_pc_dec;
    logic [SAMP_W-1:0] w_pc_cnt;
    logic              w_latch;
    logic              w_abort;
    logic              w_done;
    logic              w_disc;

    capture_cnt #(.W(FL_W)) u_flush_cnt (
        .CLK300MHZ (CLK300MHZ),
        .RST       (RST),
        .i_load    (w_fl_load),
        .i_val     (FL_W'(FLUSH_CYC - 1)),
        .i_dec     (w_fl_dec),
        .o_cnt     (w_fl_cnt)
    );

    capture_cnt #(.W(SAMP_W)) u_post_cnt (
        .CLK300MHZ (CLK300MHZ),
        .RST       (RST),
        .i_load    (w_pc_load),
        .i_val     (r_post_q),
        .i_dec     (w_pc_dec),
        .o_cnt     (w_pc_cnt)
    );

    always_ff @(posedge CLK300MHZ or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_fl_load = 1'b0;
        w_fl_dec  = 1'b0;
        w_pc_load = 1'b0;
        w_pc_dec  = 1'b0;
        w_latch   = 1'b0;
        w_abort   = 1'b0;
        w_done    = 1'b0;
        w_disc    = 1'b0;
        if (abort_stb && (r_state != S_IDLE)) begin
            w_next    = S_FLUSH;
            w_fl_load = 1'b1;
            w_abort   = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_stb) begin
                        w_next    = S_FLUSH;
                        w_fl_load = 1'b1;
                        w_latch   = 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (w_fl_cnt == '0) begin
                        w_next = r_aborting ? S_IDLE : S_PRE_FILL;
                    end else begin
                        w_fl_dec = 1'b1;
                    end
                end
                S_PRE_FILL: begin
                    if (fifo_count >= r_pre_q) begin
                        w_next = S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    // the trigger-cycle word is still pre-trigger
                    w_disc = samp_stb && (fifo_count > r_pre_q);
                    if (trigger_in) begin
                        if (r_post_q == '0) begin
                            w_next = S_DRAIN;
                        end else begin
                            w_pc_load = 1'b1;
                            w_next    = S_POST;
                        end
                    end
                end
                S_POST: begin
                    w_pc_dec = samp_stb;
                    if (w_pc_cnt == '0) begin
                        w_next = S_DRAIN;
                    end else if (samp_stb && (w_pc_cnt == SAMP_W'(1))) begin
                        w_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == '0) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK300MHZ or posedge RST) begin
        if (RST) begin
            r_pre_q      <= '0;
            r_post_q     <= '0;
            r_aborting   <= 1'b0;
            r_fifo_flush <= 1'b0;
            r_wr_gate    <= 1'b0;
            r_discard    <= 1'b0;
            r_drain      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_latch) begin
                r_pre_q  <= pre_depth;
                r_post_q <= post_words;
            end
            if (w_latch) begin
                r_aborting <= 1'b0;
            end else if (w_abort) begin
                r_aborting <= 1'b1;
            end
            r_fifo_flush <= (w_next == S_FLUSH);
            r_wr_gate    <= (w_next == S_PRE_FILL)
                         || (w_next == S_WAIT_TRIG)
                         || (w_next == S_POST);
            r_discard    <= w_disc;
            r_drain      <= (w_next == S_DRAIN);
            r_busy       <= (w_next != S_IDLE);
            r_done       <= w_done;
        end
    end

    assign fifo_flush = r_fifo_flush;
    assign wr_gate    = r_wr_gate;
    assign discard_rd = r_discard;
    assign drain_en   = r_drain;
    assign busy       = r_busy;
    assign done_stb   = r_done;
    assign state_o    = r_state;

endmodule

// File: tb/tb_capture_seq.sv
// Randomised bench for capture_seq with a FIFO environment model
// and a behavioural reference of the capture sequence.
module tb_capture_seq;

    localparam int CNT_W     = 17;
    localparam int SAMP_W    = 24;
    localparam int FLUSH_CYC = 16;

    logic              CLK300MHZ = 1'b0;
    logic              RST       = 1'b1;
    logic              start_stb = 1'b0;
    logic              abort_stb = 1'b0;
    logic [CNT_W-1:0]  pre_depth = '0;
    logic [SAMP_W-1:0] post_words = '0;
    logic              trigger_in = 1'b0;
    logic [CNT_W-1:0]  fifo_count = '0;
    logic              samp_stb = 1'b0;
    logic              fifo_flush;
    logic              wr_gate;
    logic              discard_rd;
    logic              drain_en;
    logic              busy;
    logic              done_stb;
    logic [2:0]        state_o;

    capture_seq #(
        .CNT_W     (CNT_W),
        .SAMP_W    (SAMP_W),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .CLK300MHZ  (CLK300MHZ),
        .RST        (RST),
        .start_stb  (start_stb),
        .abort_stb  (abort_stb),
        .pre_depth  (pre_depth),
        .post_words (post_words),
        .trigger_in (trigger_in),
        .fifo_count (fifo_count),
        .samp_stb   (samp_stb),
        .fifo_flush (fifo_flush),
        .wr_gate    (wr_gate),
        .discard_rd (discard_rd),
        .drain_en   (drain_en),
        .busy       (busy),
        .done_stb   (done_stb),
        .state_o    (state_o)
    );

    always #4 CLK300MHZ = ~CLK300MHZ;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: phase 0 idle,1 flush,2 prefill,3 armed,4 post,5 drain
    int m_st   = 0;
    int m_left = 0;
    int m_plft = 0;
    int m_pre  = 0;
    int m_post = 0;
    bit m_ab   = 0;
    bit m_disc = 0;
    bit m_done = 0;
    int occ    = 0;

    function automatic logic [8:0] dut_vec();
        return {state_o, fifo_flush, wr_gate, discard_rd,
                drain_en, busy, done_stb};
    endfunction

    function automatic logic [8:0] m_vec();
        logic [2:0] s;
        s = 3'(m_st);
        return {s, m_st == 1, (m_st >= 2) && (m_st <= 4), m_disc,
                m_st == 5, m_st != 0, m_done};
    endfunction

    task automatic model_step(input logic st, ab, trig, samp, input int cnt);
        int ns;
        ns     = m_st;
        m_disc = 0;
        m_done = 0;
        if (ab && (m_st != 0)) begin
            ns     = 1;
            m_left = FLUSH_CYC;
            m_ab   = 1;
        end else begin
            case (m_st)
                0: if (st) begin
                    m_pre  = int'(pre_depth);
                    m_post = int'(post_words);
                    m_left = FLUSH_CYC;
                    m_ab   = 0;
                    ns     = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) ns = m_ab ? 0 : 2;
                end
                2: if (cnt >= m_pre) ns = 3;
                3: begin
                    m_disc = samp && (cnt > m_pre);
                    if (trig) begin
                        if (m_post == 0) begin
                            ns = 5;
                        end else begin
                            m_plft = m_post;
                            ns     = 4;
                        end
                    end
                end
                4: if (samp) begin
                    m_plft--;
                    if (m_plft == 0) ns = 5;
                end
                5: if (cnt == 0) begin
                    m_done = 1;
                    ns     = 0;
                end
                default: ns = 0;
            endcase
        end
        m_st = ns;
    endtask

    task automatic tick(input logic st, ab, trig, ws);
        logic p_flush, p_pop;
        int   c;
        p_flush    = fifo_flush;
        p_pop      = discard_rd | drain_en;
        start_stb  = st;
        abort_stb  = ab;
        trigger_in = trig;
        samp_stb   = ws & wr_gate;
        fifo_count = CNT_W'(occ);
        c          = occ;
        @(posedge CLK300MHZ);
        model_step(st, ab, trig, samp_stb, c);
        if (p_flush) begin
            occ = 0;
        end else begin
            occ = occ + int'(samp_stb) - int'(p_pop && (c > 0));
        end
        @(negedge CLK300MHZ);
        chk("outs", dut_vec(), m_vec());
    endtask

    task automatic async_reset();
        #1 RST = 1'b1;
        #1 chk("async_rst_outs", dut_vec(), 0);
        @(negedge CLK300MHZ);
        @(negedge CLK300MHZ);
        RST    = 1'b0;
        m_st   = 0;
        m_disc = 0;
        m_done = 0;
        occ    = 0;
    endtask

    task automatic run_cap(input int pre, post, mode, trig_at,
                           input bit ab_post2, st_in_flush, rst_drain);
        int flush_c = 0, pre_c = 0, wait_c = 0, post_w = 0, done_c = 0;
        int occ_bad = 0, sb;
        bit aborted = 0, rst_hit = 0;
        logic ws, tr, ab, st;
        pre_depth  = CNT_W'(pre);
        post_words = SAMP_W'(post);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        flush_c += int'(fifo_flush);
        for (int i = 0; i < 4000 && m_st != 0; i++) begin
            case (mode)
                0:       ws = 1'b1;
                1:       ws = (i % 3) == 0;
                default: ws = 1'($urandom_range(0, 1));
            endcase
            tr = (trig_at >= 0) && (i >= trig_at);
            ab = ab_post2 && !aborted && (m_st == 4) && (m_plft == 2);
            if (ab) aborted = 1;
            st = st_in_flush && (m_st == 1) && ((i % 5) == 0);
            sb = int'(state_o);
            tick(st, ab, tr, ws);
            flush_c += int'(fifo_flush);
            pre_c   += int'(state_o == 3'd2);
            wait_c  += int'(state_o == 3'd3);
            done_c  += int'(done_stb);
            if ((sb == 4) && samp_stb) post_w++;
            if ((m_st == 3) && !samp_stb && !m_disc
                && ((occ < pre) || (occ > pre + 1))) occ_bad++;
            if (rst_drain && (m_st == 5) && (occ > 2)) begin
                async_reset();
                rst_hit = 1;
                break;
            end
        end
        if (!rst_hit) begin
            chk("back_to_idle", m_st, 0);
            chk("flush_len", flush_c, aborted ? 2 * FLUSH_CYC : FLUSH_CYC);
            chk("done_cnt", done_c, aborted ? 0 : 1);
            chk("occ_band", occ_bad, 0);
            if (!aborted) chk("post_words", post_w, post);
            if (pre == 0) chk("prefill_len", pre_c, 1);
            if (trig_at == 0) chk("wait_len", wait_c, 1);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge CLK300MHZ);
        chk("reset_outs", dut_vec(), 0);
        RST = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        run_cap(8, 4, 0, 40, 0, 0, 0);
        run_cap(8, 3, 1, 140, 0, 0, 0);
        run_cap(0, 0, 2, 30, 0, 0, 0);
        run_cap(5, 3, 2, 0, 0, 0, 0);
        run_cap(6, 5, 0, 30, 1, 1, 0);
        run_cap(8, 4, 0, 30, 0, 0, 1);
        run_cap(8, 4, 0, 30, 0, 0, 0);
        repeat (8) begin
            run_cap($urandom_range(0, 20), $urandom_range(0, 12), 2,
                    $urandom_range(0, 80), 0, 0, 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
